// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  prem_q, prem_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N:0]    rem_sh_c;
  logic          ge_c;
  logic [N-1:0]  prem_nxt_c;
  logic [N-1:0]  sreg_nxt_c;
  logic [N-1:0]  dvd_mag_c;
  logic [N-1:0]  dvs_mag_c;
  logic [N-1:0]  quot_fin_c;
  logic [N-1:0]  rem_fin_c;

  // One restoring step: remainder always stays below the divisor, so N bits hold it.
  assign rem_sh_c   = {prem_q, sreg_q[N-1]};
  assign ge_c       = (rem_sh_c >= {1'b0, dvs_q});
  assign prem_nxt_c = ge_c ? (rem_sh_c[N-1:0] - dvs_q) : rem_sh_c[N-1:0];
  assign sreg_nxt_c = {sreg_q[N-2:0], ge_c};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign dvd_mag_c  = dividend[N-1] ? (~dividend + N'(1)) : dividend;
  assign dvs_mag_c  = divisor[N-1]  ? (~divisor + N'(1))  : divisor;
  assign quot_fin_c = negq_q ? (~sreg_nxt_c + N'(1)) : sreg_nxt_c;
  assign rem_fin_c  = negr_q ? (~prem_nxt_c + N'(1)) : prem_nxt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == S_IDLE && start && divisor != '0) begin
      negq_d = dividend[N-1] ^ divisor[N-1];
      negr_d = dividend[N-1];
    end
  end
`else
  assign dvd_mag_c  = dividend;
  assign dvs_mag_c  = divisor;
  assign quot_fin_c = sreg_nxt_c;
  assign rem_fin_c  = prem_nxt_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      sreg_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      sreg_q  <= sreg_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // busy/done are registered from the next state so they line up with RUN/FIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    sreg_d  = sreg_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = S_FIN;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = CW'(N - 1);
            prem_d  = '0;
            sreg_d  = dvd_mag_c;
            dvs_d   = dvs_mag_c;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        prem_d = prem_nxt_c;
        sreg_d = sreg_nxt_c;
        if (cnt_q == '0) begin
          state_d = S_FIN;
          quot_d  = quot_fin_c;
          rem_d   = rem_fin_c;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8): vector table plus multi-cycle corner sequences.
module tb_seq_divider;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                     input logic [7:0] r, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.z = z;
    vecs.push_back(v);
  endtask

  // Drive a start in IDLE; returns sampling cycle k+1.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follow cycles k+1..k+lat checking busy/done, then results, then the idle cycle.
  task automatic expect_op(input string tag, input int lat, input logic [7:0] eq,
                           input logic [7:0] er, input logic ez, input bit scramble);
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(i < lat));
      chk({tag, "_done"}, 32'(done), 32'(i == lat));
      if (scramble) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        start    = (i == 3);
      end
    end
    start = 1'b0;
    chk({tag, "_quot"}, 32'(quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    @(posedge clk);
    #1;
    chk({tag, "_done_after"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] rr;
    int         done_seen;

`ifdef SEQ_DIVIDER_SIGNED_EN
    add(8'd100, 8'd7,  8'd14,  8'd2,  1'b0);
    add(8'hF9,  8'd2,  8'hFD,  8'hFF, 1'b0);
    add(8'd7,   8'hFE, 8'hFD,  8'h01, 1'b0);
    add(8'h80,  8'hFF, 8'h80,  8'h00, 1'b0);
    add(8'hF9,  8'hFE, 8'd3,   8'hFF, 1'b0);
    add(8'hF9,  8'd0,  8'hFF,  8'hF9, 1'b1);
    add(8'd9,   8'd3,  8'd3,   8'd0,  1'b0);
    add(8'd127, 8'h80, 8'd0,   8'd127, 1'b0);
    rq = 8'hEE;
    rr = 8'hFE;
`else
    add(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    add(8'd3,   8'd10,  8'd0,   8'd3,  1'b0);
    add(8'd0,   8'd9,   8'd0,   8'd0,  1'b0);
    add(8'd5,   8'd0,   8'hFF,  8'd5,  1'b1);
    add(8'd9,   8'd3,   8'd3,   8'd0,  1'b0);
    add(8'd1,   8'd255, 8'd0,   8'd1,  1'b0);
    add(8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
    add(8'd254, 8'd16,  8'd15,  8'd14, 1'b0);
    add(8'd128, 8'd2,   8'd64,  8'd0,  1'b0);
    rq = 8'd66;
    rr = 8'd2;
`endif

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // 100/7 with result hold check five cycles later
    launch(8'd100, 8'd7);
    expect_op("basic", N + 1, 8'd14, 8'd2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_quot", 32'(quotient), 32'd14);
    chk("hold_rem", 32'(remainder), 32'd2);

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      expect_op($sformatf("vec%0d", i), vecs[i].z ? 1 : N + 1,
                vecs[i].q, vecs[i].r, vecs[i].z, 1'b0);
    end

    // Start pulsed mid-run with operands changing every cycle is ignored
    launch(8'd100, 8'd7);
    expect_op("ignore", N + 1, 8'd14, 8'd2, 1'b0, 1'b1);

    // Reset mid-run aborts without a done pulse
    launch(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quot", 32'(quotient), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    launch(8'd200, 8'd3);
    expect_op("after_abort", N + 1, rq, rr, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring unsigned divider, one quotient bit per clock. It is the inverse arithmetic companion to the team's combinational array multiplier.
- Accepts an N-bit dividend and an N-bit divisor on a start strobe. Returns the quotient and remainder after N iteration cycles, with a busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath, where area matters more than latency.

Parameters:
- N, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  N  numerator; captured on an accepted start
- divisor  input  N  denominator; captured on an accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  N  result quotient; held until the next accepted start
- remainder  output  N  result remainder; held until the next accepted start
- div_by_zero  output  1  flag for the last operation; held with the results

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE;
  - busy, done, quotient, remainder, div_by_zero all become 0;
  - the iteration counter and working registers clear.
  - rst takes priority over every other input in every state.
- States: IDLE, RUN, FIN.
- IDLE:
  - start low: stay in IDLE, outputs hold.
  - start high, divisor != 0: capture both operands, clear the partial remainder, set the counter to N-1, go to RUN.
  - start high, divisor == 0: go to FIN with quotient = all ones, remainder = dividend, div_by_zero = 1. busy is never asserted.
- RUN (one iteration per cycle, MSB of the dividend first):
  - shift {partial remainder, dividend shift register} left by 1;
  - trial = partial remainder - divisor, computed at N+1 bits;
  - trial non-negative: partial remainder = trial, shift in quotient bit 1; otherwise shift in quotient bit 0;
  - at counter == 0, go to FIN; otherwise decrement the counter.
- FIN:
  - quotient and remainder are loaded into the output registers on entry;
  - done = 1 for exactly this cycle;
  - next state is IDLE unconditionally.
- Latency, with start accepted at edge k:
  - busy is high for cycles k+1 .. k+N;
  - done is high in cycle k+N+1, with busy low;
  - for divide-by-zero, done is high in cycle k+1.
- Boundary rules:
  - start asserted in RUN or FIN is ignored and not queued.
  - Operand inputs may change freely after capture without affecting the result.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- Result invariants for an unsigned divisor d != 0: quotient*d + remainder == dividend, and remainder < d.
- div_by_zero clears to 0 on the next accepted start with a non-zero divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands and results are two's complement.
  - On capture, magnitudes are taken and the operand signs are registered.
  - Unsigned iteration runs as above.
  - On entry to FIN, the quotient is negated if the operand signs differ, and the remainder is negated if the dividend was negative. The quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow: MIN / -1 gives quotient = MIN (wraps), remainder = 0, div_by_zero = 0.
  - Divide-by-zero: quotient = all ones (-1), remainder = dividend.
  - Latency is unchanged.
- Undefined: purely unsigned, with no sign logic synthesized.

Test Plan:
- N=8, dividend=100, divisor=7, start at edge k -> busy high for cycles k+1..k+8; done in cycle k+9 with quotient=14, remainder=2, div_by_zero=0; outputs still 14/2 five cycles later.
- N=8, 255/1, then 3/10, then 0/9 -> quotient/remainder of 255/0, then 0/3, then 0/0; each done exactly 9 cycles after its start.
- N=8, 5/0 -> done in cycle k+1, busy never high, quotient=0xFF, remainder=5, div_by_zero=1; a following 9/3 clears the flag and gives 3/0.
- N=8, start 100/7, then pulse start with 50/5 at cycle k+3 and hold both inputs changing -> second start ignored; result 14/2 at cycle k+9.
- N=8, start 200/3, rst high at cycle k+4 -> all outputs 0 the next cycle, no done pulse; a new start of 200/3 gives 66/2.
- SEQ_DIVIDER_SIGNED_EN, N=8:
  - -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1);
  - 7/-2 -> quotient=0xFD, remainder=0x01;
  - -128/-1 -> quotient=0x80, remainder=0.
